// File: rtl/netwalk_exec_pkg.sv
// Shared widths and field layout for the netwalk action-table engine.
// The program word is {flag, set}, with the action set in the low bits.
package netwalk_exec_pkg;

  localparam int ACTION_FLAG_WIDTH_DEF = 16;
  localparam int ACTION_SET_WIDTH_DEF  = 356;
  localparam int TCAM_ADDR_WIDTH_DEF   = 6;
  localparam int HEADER_WIDTH_DEF      = 512;
  localparam int COUNTER_WIDTH_DEF     = 32;

  localparam int SET_FIELD_LSB = 0;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_ZERO,
    CNT_ONE,
    CNT_INC
  } cnt_op_e;

  function automatic int program_data_width(input int flag_w, input int set_w);
    return flag_w + set_w;
  endfunction

  function automatic int flag_field_lsb(input int set_w);
    return SET_FIELD_LSB + set_w;
  endfunction

endpackage

// File: rtl/netwalk_hit_counter_bank.sv
// Per-entry saturating hit counters with a one-cycle read port and read-clear.
// Zeroing from program/delete beats everything; read-clear with a same-cycle hit leaves 1.
module netwalk_hit_counter_bank
  import netwalk_exec_pkg::*;
#(
  parameter int ADDR_WIDTH    = TCAM_ADDR_WIDTH_DEF,
  parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc_en,
  input  logic [ADDR_WIDTH-1:0]    inc_addr,
  input  logic                     zero_en,
  input  logic [ADDR_WIDTH-1:0]    zero_addr,
  input  logic                     rd_en,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic                     rd_clear,
  output logic [COUNTER_WIDTH-1:0] rd_data,
  output logic                     rd_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_UNIT = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] cnt_q [DEPTH];
  cnt_op_e                  op    [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      op[i] = CNT_HOLD;
      if (zero_en && zero_addr == ADDR_WIDTH'(i)) begin
        op[i] = CNT_ZERO;
      end else if (rd_en && rd_clear && rd_addr == ADDR_WIDTH'(i)) begin
        op[i] = (inc_en && inc_addr == ADDR_WIDTH'(i)) ? CNT_ONE : CNT_ZERO;
      end else if (inc_en && inc_addr == ADDR_WIDTH'(i) && cnt_q[i] != CNT_MAX) begin
        op[i] = CNT_INC;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        case (op[i])
          CNT_ZERO: cnt_q[i] <= '0;
          CNT_ONE:  cnt_q[i] <= CNT_UNIT;
          CNT_INC:  cnt_q[i] <= cnt_q[i] + CNT_UNIT;
          default:  cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  // Read returns the value before this cycle's update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= cnt_q[rd_addr];
      end
    end
  end

endmodule

// File: rtl/netwalk_action_table_engine.sv
// Two-stage action lookup: register request, read table (write-first forwarded), register result.
// Hit counters are bumped in the result cycle by netwalk_hit_counter_bank.
module netwalk_action_table_engine
  import netwalk_exec_pkg::*;
#(
  parameter int ACTION_FLAG_WIDTH = ACTION_FLAG_WIDTH_DEF,
  parameter int ACTION_SET_WIDTH  = ACTION_SET_WIDTH_DEF,
  parameter int TCAM_ADDR_WIDTH   = TCAM_ADDR_WIDTH_DEF,
  parameter int HEADER_WIDTH      = HEADER_WIDTH_DEF,
  parameter int COUNTER_WIDTH     = COUNTER_WIDTH_DEF,
  localparam int PROGRAM_DATA_WIDTH = program_data_width(ACTION_FLAG_WIDTH, ACTION_SET_WIDTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PROGRAM_DATA_WIDTH-1:0] exec_program_data,
  input  logic [TCAM_ADDR_WIDTH-1:0]    exec_program_addr,
  input  logic                          exec_program_enable,
  input  logic                          exec_delete_enable,
  input  logic                          exec_default_program_enable,
  input  logic                          exec_lookup_valid,
  input  logic                          exec_of_match_found,
  input  logic [TCAM_ADDR_WIDTH-1:0]    exec_of_match_addr,
  input  logic [HEADER_WIDTH-1:0]       pkt_header_in,
  output logic [ACTION_FLAG_WIDTH-1:0]  exec_action_flag,
  output logic [ACTION_SET_WIDTH-1:0]   exec_action_set,
  output logic                          exec_action_enable,
  output logic                          exec_action_miss,
  output logic [HEADER_WIDTH-1:0]       pkt_header_out,
  input  logic                          stat_rd_en,
  input  logic [TCAM_ADDR_WIDTH-1:0]    stat_rd_addr,
  input  logic                          stat_rd_clear,
  output logic [COUNTER_WIDTH-1:0]      stat_rd_data,
  output logic                          stat_rd_valid
);

  localparam int DEPTH    = 1 << TCAM_ADDR_WIDTH;
  localparam int FLAG_LSB = flag_field_lsb(ACTION_SET_WIDTH);

  logic [PROGRAM_DATA_WIDTH-1:0] table_data [DEPTH];
  logic [DEPTH-1:0]              table_valid;
  logic [PROGRAM_DATA_WIDTH-1:0] default_q;

  logic                          s1_valid;
  logic                          s1_found;
  logic [TCAM_ADDR_WIDTH-1:0]    s1_addr;
  logic [HEADER_WIDTH-1:0]       s1_header;

  logic                          rd_valid_eff;
  logic [PROGRAM_DATA_WIDTH-1:0] rd_data_eff;
  logic                          hit;
  logic [PROGRAM_DATA_WIDTH-1:0] result;

  logic [PROGRAM_DATA_WIDTH-1:0] action_q;
  logic                          inc_en_q;
  logic [TCAM_ADDR_WIDTH-1:0]    inc_addr_q;

  // Data is not reset; table_valid gates every use of it.
  always_ff @(posedge clk) begin
    if (exec_program_enable && !exec_delete_enable) begin
      table_data[exec_program_addr] <= exec_program_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      table_valid <= '0;
    end else if (exec_delete_enable) begin
      table_valid[exec_program_addr] <= 1'b0;
    end else if (exec_program_enable) begin
      table_valid[exec_program_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      default_q <= '0;
    end else if (exec_default_program_enable) begin
      default_q <= exec_program_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_found  <= 1'b0;
      s1_addr   <= '0;
      s1_header <= '0;
    end else begin
      s1_valid  <= exec_lookup_valid;
      s1_found  <= exec_of_match_found;
      s1_addr   <= exec_of_match_addr;
      s1_header <= pkt_header_in;
    end
  end

  // A write landing on the entry being read this cycle is seen by the lookup.
  always_comb begin
    rd_valid_eff = table_valid[s1_addr];
    rd_data_eff  = table_data[s1_addr];
    if (exec_delete_enable && exec_program_addr == s1_addr) begin
      rd_valid_eff = 1'b0;
    end else if (exec_program_enable && exec_program_addr == s1_addr) begin
      rd_valid_eff = 1'b1;
      rd_data_eff  = exec_program_data;
    end
    hit    = s1_found && rd_valid_eff;
    result = hit ? rd_data_eff : default_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_action_enable <= 1'b0;
      exec_action_miss   <= 1'b0;
      action_q           <= '0;
      pkt_header_out     <= '0;
      inc_en_q           <= 1'b0;
      inc_addr_q         <= '0;
    end else begin
      exec_action_enable <= s1_valid;
      inc_en_q           <= s1_valid && hit;
      inc_addr_q         <= s1_addr;
      if (s1_valid) begin
        action_q         <= result;
        exec_action_miss <= !hit;
        pkt_header_out   <= s1_header;
      end
    end
  end

  assign exec_action_flag = action_q[FLAG_LSB +: ACTION_FLAG_WIDTH];
  assign exec_action_set  = action_q[SET_FIELD_LSB +: ACTION_SET_WIDTH];

  netwalk_hit_counter_bank #(
    .ADDR_WIDTH    (TCAM_ADDR_WIDTH),
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_hit_counters (
    .clk       (clk),
    .reset     (reset),
    .inc_en    (inc_en_q),
    .inc_addr  (inc_addr_q),
    .zero_en   (exec_program_enable || exec_delete_enable),
    .zero_addr (exec_program_addr),
    .rd_en     (stat_rd_en),
    .rd_addr   (stat_rd_addr),
    .rd_clear  (stat_rd_clear),
    .rd_data   (stat_rd_data),
    .rd_valid  (stat_rd_valid)
  );

endmodule

// File: tb/tb_netwalk_action_table_engine.sv
// Bench for netwalk_action_table_engine: directed scenarios plus random traffic against a
// transaction-level table model; a second instance with 4-bit counters covers saturation.
module tb_netwalk_action_table_engine;
  import netwalk_exec_pkg::*;

  localparam int FW    = ACTION_FLAG_WIDTH_DEF;
  localparam int SW    = ACTION_SET_WIDTH_DEF;
  localparam int AW    = TCAM_ADDR_WIDTH_DEF;
  localparam int HW    = HEADER_WIDTH_DEF;
  localparam int PW    = FW + SW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] exec_program_data;
  logic [AW-1:0] exec_program_addr;
  logic          exec_program_enable;
  logic          exec_delete_enable;
  logic          exec_default_program_enable;
  logic          exec_lookup_valid;
  logic          exec_of_match_found;
  logic [AW-1:0] exec_of_match_addr;
  logic [HW-1:0] pkt_header_in;
  logic          stat_rd_en;
  logic [AW-1:0] stat_rd_addr;
  logic          stat_rd_clear;

  logic [FW-1:0] exec_action_flag, sat_flag;
  logic [SW-1:0] exec_action_set, sat_set;
  logic          exec_action_enable, sat_enable;
  logic          exec_action_miss, sat_miss;
  logic [HW-1:0] pkt_header_out, sat_header;
  logic [31:0]   stat_rd_data;
  logic [3:0]    sat_rd_data;
  logic          stat_rd_valid, sat_rd_valid;

  always #5 clk = ~clk;

  netwalk_action_table_engine dut (
    .clk(clk), .reset(reset),
    .exec_program_data(exec_program_data), .exec_program_addr(exec_program_addr),
    .exec_program_enable(exec_program_enable), .exec_delete_enable(exec_delete_enable),
    .exec_default_program_enable(exec_default_program_enable),
    .exec_lookup_valid(exec_lookup_valid), .exec_of_match_found(exec_of_match_found),
    .exec_of_match_addr(exec_of_match_addr), .pkt_header_in(pkt_header_in),
    .exec_action_flag(exec_action_flag), .exec_action_set(exec_action_set),
    .exec_action_enable(exec_action_enable), .exec_action_miss(exec_action_miss),
    .pkt_header_out(pkt_header_out),
    .stat_rd_en(stat_rd_en), .stat_rd_addr(stat_rd_addr), .stat_rd_clear(stat_rd_clear),
    .stat_rd_data(stat_rd_data), .stat_rd_valid(stat_rd_valid)
  );

  netwalk_action_table_engine #(.COUNTER_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset),
    .exec_program_data(exec_program_data), .exec_program_addr(exec_program_addr),
    .exec_program_enable(exec_program_enable), .exec_delete_enable(exec_delete_enable),
    .exec_default_program_enable(exec_default_program_enable),
    .exec_lookup_valid(exec_lookup_valid), .exec_of_match_found(exec_of_match_found),
    .exec_of_match_addr(exec_of_match_addr), .pkt_header_in(pkt_header_in),
    .exec_action_flag(sat_flag), .exec_action_set(sat_set),
    .exec_action_enable(sat_enable), .exec_action_miss(sat_miss),
    .pkt_header_out(sat_header),
    .stat_rd_en(stat_rd_en), .stat_rd_addr(stat_rd_addr), .stat_rd_clear(stat_rd_clear),
    .stat_rd_data(sat_rd_data), .stat_rd_valid(sat_rd_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: table contents, default action, counters, in-flight request.
  bit              m_valid [DEPTH];
  logic [PW-1:0]   m_data  [DEPTH];
  logic [PW-1:0]   m_dflt;
  longint unsigned m_cnt32 [DEPTH];
  int              m_cnt4  [DEPTH];
  bit              req_v, req_f;
  int              req_a;
  logic [HW-1:0]   req_h;
  bit              bump_v;
  int              bump_a;
  bit              e_en, e_miss, e_sv;
  logic [PW-1:0]   e_act;
  logic [HW-1:0]   e_hdr;
  longint unsigned e_sd32;
  int              e_sd4;

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 5) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      m_valid[a] = 0;
      m_cnt32[a] = 0;
      m_cnt4[a]  = 0;
    end
    m_dflt = '0;
    req_v = 0; bump_v = 0;
    e_en = 0; e_miss = 0; e_sv = 0; e_act = '0; e_hdr = '0; e_sd32 = 0; e_sd4 = 0;
  endtask

  // One clock of the rules, applied to the inputs currently driven.
  task automatic model_cycle();
    bit z, clr, inc, hit;
    e_sv = stat_rd_en;
    if (stat_rd_en) begin
      e_sd32 = m_cnt32[stat_rd_addr];
      e_sd4  = m_cnt4[stat_rd_addr];
    end
    for (int a = 0; a < DEPTH; a++) begin
      z   = (exec_program_enable || exec_delete_enable) && exec_program_addr == AW'(a);
      clr = stat_rd_en && stat_rd_clear && stat_rd_addr == AW'(a);
      inc = bump_v && bump_a == a;
      if (z) begin
        m_cnt32[a] = 0; m_cnt4[a] = 0;
      end else if (clr) begin
        m_cnt32[a] = inc ? 1 : 0; m_cnt4[a] = inc ? 1 : 0;
      end else if (inc) begin
        if (m_cnt32[a] < 64'hFFFF_FFFF) m_cnt32[a]++;
        if (m_cnt4[a] < 15) m_cnt4[a]++;
      end
    end
    if (exec_delete_enable) m_valid[exec_program_addr] = 0;
    else if (exec_program_enable) begin
      m_valid[exec_program_addr] = 1;
      m_data[exec_program_addr]  = exec_program_data;
    end
    bump_v = 0;
    e_en   = req_v;
    if (req_v) begin
      hit    = req_f && m_valid[req_a];
      e_act  = hit ? m_data[req_a] : m_dflt;
      e_miss = !hit;
      e_hdr  = req_h;
      bump_v = hit;
      bump_a = req_a;
    end
    if (exec_default_program_enable) m_dflt = exec_program_data;
    req_v = exec_lookup_valid;
    req_f = exec_of_match_found;
    req_a = int'(exec_of_match_addr);
    req_h = pkt_header_in;
  endtask

  task automatic check_outputs();
    chk("enable", exec_action_enable, e_en);
    chk("miss", exec_action_miss, e_miss);
    chk("action", {exec_action_flag, exec_action_set}, e_act);
    chk("header", pkt_header_out, e_hdr);
    chk("rd_valid", stat_rd_valid, e_sv);
    chk("sat_enable", sat_enable, e_en);
    chk("sat_action", {sat_flag, sat_set}, e_act);
    chk("sat_rd_valid", sat_rd_valid, e_sv);
    if (e_sv) begin
      chk("rd_data", stat_rd_data, e_sd32);
      chk("sat_rd_data", sat_rd_data, e_sd4);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_enable"}, exec_action_enable, 0);
    chk({tag, "_miss"}, exec_action_miss, 0);
    chk({tag, "_action"}, {exec_action_flag, exec_action_set}, 0);
    chk({tag, "_header"}, pkt_header_out, 0);
    chk({tag, "_rd_valid"}, stat_rd_valid, 0);
    chk({tag, "_rd_data"}, stat_rd_data, 0);
    chk({tag, "_sat_rd_data"}, sat_rd_data, 0);
  endtask

  task automatic idle_inputs();
    logic [511:0] r;
    r = rand512();
    exec_program_data = '0;
    exec_program_addr = '0;
    exec_program_enable = 0;
    exec_delete_enable = 0;
    exec_default_program_enable = 0;
    exec_lookup_valid = 0;
    exec_of_match_found = 0;
    exec_of_match_addr = '0;
    pkt_header_in = r;
    stat_rd_en = 0;
    stat_rd_addr = '0;
    stat_rd_clear = 0;
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    check_outputs();
    idle_inputs();
  endtask

  task automatic lookup(input bit found, input int a);
    exec_lookup_valid = 1;
    exec_of_match_found = found;
    exec_of_match_addr = AW'(a);
    tick();
  endtask

  task automatic program_entry(input int a, input logic [PW-1:0] d);
    exec_program_enable = 1;
    exec_program_addr = AW'(a);
    exec_program_data = d;
    tick();
  endtask

  task automatic stat_read(input int a, input bit clear);
    stat_rd_en = 1;
    stat_rd_addr = AW'(a);
    stat_rd_clear = clear;
    tick();
  endtask

  initial begin
    logic [511:0] r;
    idle_inputs();
    model_reset();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("por");
    reset = 1;

    // Program 1..4, hit on 3.
    for (int a = 1; a <= 4; a++) program_entry(a, PW'(a));
    lookup(1, 3);
    tick();
    chk("hit3_action", {exec_action_flag, exec_action_set}, 3);
    chk("hit3_miss", exec_action_miss, 0);
    tick();

    // Default action on no-match and on never-programmed entry.
    exec_default_program_enable = 1;
    exec_program_data = PW'(8'hAA);
    tick();
    tick();
    lookup(0, 1);
    lookup(1, 5);
    chk("nomatch_action", {exec_action_flag, exec_action_set}, 'hAA);
    chk("nomatch_miss", exec_action_miss, 1);
    tick();
    chk("invalid_action", {exec_action_flag, exec_action_set}, 'hAA);
    chk("invalid_miss", exec_action_miss, 1);

    // Write-first forwarding, then delete beating program.
    lookup(1, 2);
    program_entry(2, PW'(7));
    chk("fwd_action", {exec_action_flag, exec_action_set}, 7);
    chk("fwd_miss", exec_action_miss, 0);
    exec_delete_enable = 1;
    program_entry(2, PW'(9));
    lookup(1, 2);
    tick();
    chk("del_wins_miss", exec_action_miss, 1);
    tick();

    // Hit counters: accumulate, read-clear, clear racing a hit, saturation.
    for (int i = 0; i < 10; i++) lookup(1, 1);
    tick();
    tick();
    stat_read(1, 1);
    chk("cnt_ten", stat_rd_data, 10);
    stat_read(1, 0);
    chk("cnt_cleared", stat_rd_data, 0);
    lookup(1, 1);
    tick();
    stat_read(1, 1);
    stat_read(1, 0);
    chk("cnt_clear_race", stat_rd_data, 1);
    for (int i = 0; i < 20; i++) lookup(1, 1);
    tick();
    tick();
    stat_read(1, 0);
    chk("cnt_sat", sat_rd_data, 15);
    chk("cnt_wide", stat_rd_data, 21);

    // Reset with two lookups in flight.
    lookup(1, 3);
    lookup(1, 4);
    reset = 0;
    #2;
    check_zero("mid_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    for (int i = 0; i < 4; i++) tick();
    for (int a = 1; a <= 4; a++) lookup(1, a);
    chk("post_rst_miss", exec_action_miss, 1);
    tick();
    tick();

    // Random traffic with address collisions.
    for (int k = 0; k < 600; k++) begin
      r = rand512();
      exec_program_enable = ($urandom_range(0, 7) == 0);
      exec_delete_enable = ($urandom_range(0, 11) == 0);
      exec_program_addr = rand_addr();
      exec_program_data = r[PW-1:0];
      exec_default_program_enable = ($urandom_range(0, 15) == 0);
      exec_lookup_valid = ($urandom_range(0, 3) != 0);
      exec_of_match_found = ($urandom_range(0, 4) != 0);
      exec_of_match_addr = rand_addr();
      stat_rd_en = ($urandom_range(0, 2) == 0);
      stat_rd_addr = rand_addr();
      stat_rd_clear = 1'($urandom_range(0, 1));
      tick();
    end
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/netwalk_action_table_engine.md
NETWALK_ACTION_TABLE_ENGINE -- requirements
Module: netwalk_action_table_engine

Interface
REQ-001 Parameters SHALL be: ACTION_FLAG_WIDTH, default 16, flag field width; ACTION_SET_WIDTH, default 356, action set width; TCAM_ADDR_WIDTH, default 6, table depth is 2**TCAM_ADDR_WIDTH; HEADER_WIDTH, default 512, header passthrough width; COUNTER_WIDTH, default 32, per-entry hit counter width; PROGRAM_DATA_WIDTH = ACTION_FLAG_WIDTH+ACTION_SET_WIDTH (derived).
REQ-002 Ports SHALL be, in order:
 clk  input  1  single clock, rising edge;
 reset  input  1  asynchronous, active-low (0 = in reset);
 exec_program_data  input  PROGRAM_DATA_WIDTH  {flag[MSBs], set[LSBs]};
 exec_program_addr  input  TCAM_ADDR_WIDTH  entry to write/delete;
 exec_program_enable  input  1  write entry, set valid;
 exec_delete_enable  input  1  clear entry valid;
 exec_default_program_enable  input  1  load table-miss action from exec_program_data;
 exec_lookup_valid  input  1  lookup request this cycle;
 exec_of_match_found  input  1  TCAM hit qualifier;
 exec_of_match_addr  input  TCAM_ADDR_WIDTH  hit address;
 pkt_header_in  input  HEADER_WIDTH  header accompanying lookup;
 exec_action_flag  output  ACTION_FLAG_WIDTH;
 exec_action_set  output  ACTION_SET_WIDTH;
 exec_action_enable  output  1  result valid strobe;
 exec_action_miss  output  1  result is default action;
 pkt_header_out  output  HEADER_WIDTH  header aligned with result;
 stat_rd_en  input  1  counter read request;
 stat_rd_addr  input  TCAM_ADDR_WIDTH;
 stat_rd_clear  input  1  clear counter after read (with stat_rd_en);
 stat_rd_data  output  COUNTER_WIDTH;
 stat_rd_valid  output  1.

Function
REQ-003 Lookup SHALL be fully pipelined: one request per cycle, exec_action_enable exactly 2 cycles after exec_lookup_valid, no backpressure.
REQ-004 Hit = exec_of_match_found AND entry valid; hit SHALL output stored flag/set, miss=0.
REQ-005 Otherwise (no match, or match to invalid entry) SHALL output default action, miss=1.
REQ-006 pkt_header_out SHALL equal the pkt_header_in sampled with the same request, updated only when exec_action_enable=1, held otherwise.
REQ-007 Action outputs SHALL hold last value when exec_action_enable=0.
REQ-008 Program SHALL write entry, set valid, zero its hit counter; delete SHALL clear valid and counter.
REQ-009 Program and delete same cycle: delete SHALL win.
REQ-010 Write to address read by an in-flight lookup in its table-read cycle SHALL be forwarded (write-first); lookup returns new contents/validity.
REQ-011 Hit SHALL increment that entry's counter at result cycle; counter saturates at all-ones, no wrap.
REQ-012 Counter read: stat_rd_data/stat_rd_valid 1 cycle after stat_rd_en; stat_rd_valid otherwise 0.
REQ-013 Read-clear coinciding with increment of same entry SHALL leave counter = 1 (no hit lost); coinciding with program/delete, counter SHALL be 0.
REQ-014 exec_default_program_enable SHALL take effect for lookups whose result is produced 2+ cycles later; same-cycle program of table entry is independent.

Reset
REQ-015 reset=0 SHALL asynchronously clear all valid bits, counters, default action, pipeline valids, all outputs to 0.
REQ-016 Lookups in flight at reset assertion SHALL be discarded; no exec_action_enable before a post-release request.
REQ-017 Table data contents need not be reset (validity gates use).

Structure
REQ-018 Shared package netwalk_exec_pkg SHALL hold width defaults, PROGRAM_DATA_WIDTH derivation, flag/set field offsets.
REQ-019 Counter array plus increment/clear/saturation SHALL be sub-module netwalk_hit_counter_bank; action storage stays inline.

Verification
REQ-020 Program addr 1..4 with data 0x1..0x4, lookup hit addr 3 -> 2 cycles later enable=1, miss=0, {flag,set}=0x3, header passthrough matches.
REQ-021 Default=0xAA, lookup match_found=0 then hit addr 5 (never programmed) -> both results 0xAA, miss=1.
REQ-022 Program addr 2 = 0x7 same cycle a lookup of addr 2 reads table -> result 0x7; delete addr 2 with program same cycle -> later hit gives miss=1.
REQ-023 10 back-to-back hits addr 1, then stat read addr 1 with clear -> stat_rd_data=10, re-read=0; clear coincident with hit -> 1; COUNTER_WIDTH=4, 20 hits -> 15.
REQ-024 Assert reset=0 with 2 lookups in flight -> all outputs 0, no enable after release, prior entries invalid (miss=1).
